md_hilo_ctrl: RTL and testbench

- Sequencer in front of the HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO, plus the MFHI/MFLO read select.
- Accepts one op from decode, latches operands and starts the external multiplier or divider. Waits for done, then issues a single write strobe to HI/LO.
- Stalls the pipeline while an op is in flight. Also handles divide-by-zero and a divider/multiplier watchdog timeout.

---
 rtl/md_pkg.sv | 43 ++++
 rtl/md_hilo_ctrl_if.sv | 54 +++++
 rtl/md_watchdog.sv | 34 +++
 rtl/md_hilo_ctrl.sv | 170 +++++++++++++++++
 tb/tb_md_hilo_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package md_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CS_W   = 2;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_WAIT,
        ST_WRITE
    } md_state_e;

    localparam logic [CS_W-1:0] CS_LO   = 2'b00;
    localparam logic [CS_W-1:0] CS_BOTH = 2'b01;
    localparam logic [CS_W-1:0] CS_RDHI = 2'b10;
    localparam logic [CS_W-1:0] CS_HI   = 2'b11;

    localparam logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF;

    // Pending HI/LO write: target select plus both data words
    typedef struct packed {
        logic [CS_W-1:0]   cs;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_wr_t;

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_hilo_ctrl_if.sv
// Decode, multiplier, divider and HI/LO signals of the multiply/divide sequencer.
interface md_hilo_ctrl_if;
    import md_pkg::*;

    logic              ena;
    logic              op_valid;
    md_op_e            op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              mf_req;
    logic              mf_hi;
    logic              stall;
    logic              md_err;

    logic              mul_start;
    logic              mul_signed;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic              mul_done;
    logic [DATA_W-1:0] mul_hi;
    logic [DATA_W-1:0] mul_lo;

    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] div_a;
    logic [DATA_W-1:0] div_b;
    logic              div_done;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_r;

    logic              hilo_ena;
    logic              hilo_wena;
    logic              hilo_ready;
    logic [CS_W-1:0]   hilo_cs;
    logic [DATA_W-1:0] hilo_hi;
    logic [DATA_W-1:0] hilo_lo;

    modport master (
        output ena, op_valid, op, rs_data, rt_data, mf_req, mf_hi,
        output mul_done, mul_hi, mul_lo, div_done, div_q, div_r,
        input  stall, md_err, mul_start, mul_signed, mul_a, mul_b,
        input  div_start, div_signed, div_a, div_b,
        input  hilo_ena, hilo_wena, hilo_ready, hilo_cs, hilo_hi, hilo_lo
    );

    modport slave (
        input  ena, op_valid, op, rs_data, rt_data, mf_req, mf_hi,
        input  mul_done, mul_hi, mul_lo, div_done, div_q, div_r,
        output stall, md_err, mul_start, mul_signed, mul_a, mul_b,
        output div_start, div_signed, div_a, div_b,
        output hilo_ena, hilo_wena, hilo_ready, hilo_cs, hilo_hi, hilo_lo
    );

endinterface

// File: rtl/md_watchdog.sv
// Wait-cycle counter that flags an expired multiply/divide after TIMEOUT cycles.
module md_watchdog #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The clearing cycle is itself the first counted wait cycle
    always_comb begin
        cnt_d = clr ? '0 : cnt_q;
        if (en) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    assign expired_c = en && !clr && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/md_hilo_ctrl.sv
// Sequences MULT/DIV/MTHI/MTLO into single HI/LO write strobes and stalls decode while busy.
module md_hilo_ctrl
    import md_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic          clk,
    input  logic          rst,
    md_hilo_ctrl_if.slave bus
);

    md_state_e         state_q,     state_d;
    logic              mul_start_q, mul_start_d;
    logic              div_start_q, div_start_d;
    logic              sgn_q,       sgn_d;
    logic [DATA_W-1:0] opa_q,       opa_d;
    logic [DATA_W-1:0] opb_q,       opb_d;
    hilo_wr_t          wr_q,        wr_d;
    logic              wena_q,      wena_d;
    logic              md_err_q,    md_err_d;

    logic wd_en_c;
    logic wd_clr_c;
    logic wd_expired_c;

    assign wd_en_c  = bus.ena && ((state_q == ST_MUL_WAIT) || (state_q == ST_DIV_WAIT));
    assign wd_clr_c = wd_en_c && (mul_start_q || div_start_q);

    md_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr       (wd_clr_c),
        .en        (wd_en_c),
        .expired_c (wd_expired_c)
    );

    // Next-state and registered-output logic; done is ignored in the start-pulse cycle
    always_comb begin
        state_d     = state_q;
        mul_start_d = 1'b0;
        div_start_d = 1'b0;
        sgn_d       = sgn_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        wr_d        = wr_q;
        wena_d      = 1'b0;
        md_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op)
                        MD_MULT, MD_MULTU: begin
                            opa_d       = bus.rs_data;
                            opb_d       = bus.rt_data;
                            sgn_d       = op_is_signed(bus.op);
                            mul_start_d = 1'b1;
                            state_d     = ST_MUL_WAIT;
                        end
                        MD_DIV, MD_DIVU: begin
                            opa_d = bus.rs_data;
                            opb_d = bus.rt_data;
                            sgn_d = op_is_signed(bus.op);
                            if (bus.rt_data == '0) begin
                                wr_d    = '{cs: CS_BOTH, hi: bus.rs_data, lo: DIV0_LO};
                                wena_d  = 1'b1;
                                state_d = ST_WRITE;
                            end else begin
                                div_start_d = 1'b1;
                                state_d     = ST_DIV_WAIT;
                            end
                        end
                        MD_MTHI: begin
                            wr_d.cs = CS_HI;
                            wr_d.hi = bus.rs_data;
                            wena_d  = 1'b1;
                            state_d = ST_WRITE;
                        end
                        MD_MTLO: begin
                            wr_d.cs = CS_LO;
                            wr_d.lo = bus.rs_data;
                            wena_d  = 1'b1;
                            state_d = ST_WRITE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                if (!mul_start_q) begin
                    if (bus.mul_done) begin
                        wr_d    = '{cs: CS_BOTH, hi: bus.mul_hi, lo: bus.mul_lo};
                        wena_d  = 1'b1;
                        state_d = ST_WRITE;
                    end else if (wd_expired_c) begin
                        md_err_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_DIV_WAIT: begin
                if (!div_start_q) begin
                    if (bus.div_done) begin
                        wr_d    = '{cs: CS_BOTH, hi: bus.div_r, lo: bus.div_q};
                        wena_d  = 1'b1;
                        state_d = ST_WRITE;
                    end else if (wd_expired_c) begin
                        md_err_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            sgn_q       <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            wr_q        <= '{cs: CS_RDHI, hi: '0, lo: '0};
            wena_q      <= 1'b0;
            md_err_q    <= 1'b0;
        end else if (bus.ena) begin
            state_q     <= state_d;
            mul_start_q <= mul_start_d;
            div_start_q <= div_start_d;
            sgn_q       <= sgn_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            wr_q        <= wr_d;
            wena_q      <= wena_d;
            md_err_q    <= md_err_d;
        end
    end

    assign bus.stall      = (bus.op_valid || bus.mf_req) && (state_q != ST_IDLE);
    assign bus.md_err     = md_err_q;
    assign bus.mul_start  = mul_start_q;
    assign bus.mul_signed = sgn_q;
    assign bus.mul_a      = opa_q;
    assign bus.mul_b      = opb_q;
    assign bus.div_start  = div_start_q;
    assign bus.div_signed = sgn_q;
    assign bus.div_a      = opa_q;
    assign bus.div_b      = opb_q;
    assign bus.hilo_ena   = bus.ena;
    assign bus.hilo_wena  = wena_q && bus.ena;
    assign bus.hilo_ready = wena_q && bus.ena;
    assign bus.hilo_hi    = wr_q.hi;
    assign bus.hilo_lo    = wr_q.lo;

    // Outside WRITE the select follows the MFHI/MFLO read request
    assign bus.hilo_cs = (state_q == ST_WRITE) ? wr_q.cs :
                         ((bus.mf_req && !bus.mf_hi) ? CS_LO : CS_RDHI);

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Scoreboard bench for md_hilo_ctrl with behavioural multiplier/divider stubs.
module tb_md_hilo_ctrl;
    import md_pkg::*;

    typedef struct {
        logic [1:0]  cs;
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_hilo_ctrl_if bus();

    md_hilo_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    wr_t sb[$];

    int   mul_lat  = 4;
    int   div_lat  = 4;
    bit   div_hang = 1'b0;
    bit   mul_spur = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [1:0] cs, input logic [31:0] hi, input logic [31:0] lo,
                             input int at);
        wr_t e;
        e.cs = cs;
        e.hi = hi;
        e.lo = lo;
        e.at = at;
        sb.push_back(e);
    endtask

    // Present op in the current cycle; afterwards op_valid stays high with a NOP
    task automatic issue(input md_op_e o, input logic [31:0] rs, input logic [31:0] rt);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        tick();
        bus.op = MD_NOP;
    endtask

    // Unit stubs: done arrives lat cycles after the start pulse is seen
    initial begin
        int          mul_cnt;
        int          div_cnt;
        logic [63:0] mul_res;
        logic [31:0] dq;
        logic [31:0] dr;
        mul_cnt = 0;
        div_cnt = 0;
        mul_res = '0;
        dq = '0;
        dr = '0;
        bus.mul_done = 1'b0;
        bus.mul_hi   = '0;
        bus.mul_lo   = '0;
        bus.div_done = 1'b0;
        bus.div_q    = '0;
        bus.div_r    = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mul_done = mul_spur;
            bus.div_done = 1'b0;
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) begin
                    bus.mul_done = 1'b1;
                    bus.mul_hi   = mul_res[63:32];
                    bus.mul_lo   = mul_res[31:0];
                end
            end
            if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    bus.div_done = 1'b1;
                    bus.div_q    = dq;
                    bus.div_r    = dr;
                end
            end
            if (bus.mul_start === 1'b1) begin
                mul_cnt = mul_lat;
                if (bus.mul_signed)
                    mul_res = {{32{bus.mul_a[31]}}, bus.mul_a} * {{32{bus.mul_b[31]}}, bus.mul_b};
                else
                    mul_res = {32'h0, bus.mul_a} * {32'h0, bus.mul_b};
            end
            if (bus.div_start === 1'b1 && !div_hang) begin
                div_cnt = div_lat;
                if (bus.div_signed) begin
                    dq = $signed(bus.div_a) / $signed(bus.div_b);
                    dr = $signed(bus.div_a) % $signed(bus.div_b);
                end else begin
                    dq = bus.div_a / bus.div_b;
                    dr = bus.div_a % bus.div_b;
                end
            end
        end
    end

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (bus.hilo_wena === 1'b1) begin
            check("wr_ready", 64'(bus.hilo_ready), 64'(1));
            if (sb.size() == 0) begin
                check("wr_unexpected", 64'(bus.hilo_wena), 64'(0));
            end else begin
                e = sb.pop_front();
                check("wr_cycle", 64'(cyc), 64'(e.at));
                check("wr_cs", 64'(bus.hilo_cs), 64'(e.cs));
                if (e.cs != CS_LO) check("wr_hi", 64'(bus.hilo_hi), 64'(e.hi));
                if (e.cs != CS_HI) check("wr_lo", 64'(bus.hilo_lo), 64'(e.lo));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int t0;
        int seen;
        bus.ena      = 1'b1;
        bus.op_valid = 1'b1;
        bus.op       = MD_NOP;
        bus.rs_data  = '0;
        bus.rt_data  = '0;
        bus.mf_req   = 1'b0;
        bus.mf_hi    = 1'b0;
        rst          = 1'b1;
        tick();
        tick();

        check("rst_stall",     64'(bus.stall),      64'(0));
        check("rst_mul_start", 64'(bus.mul_start),  64'(0));
        check("rst_div_start", 64'(bus.div_start),  64'(0));
        check("rst_wena",      64'(bus.hilo_wena),  64'(0));
        check("rst_ready",     64'(bus.hilo_ready), 64'(0));
        check("rst_md_err",    64'(bus.md_err),     64'(0));
        check("rst_cs",        64'(bus.hilo_cs),    64'(2'b10));
        check("rst_mul_a",     64'(bus.mul_a),      64'(0));
        check("rst_hilo_hi",   64'(bus.hilo_hi),    64'(0));
        check("rst_hilo_ena",  64'(bus.hilo_ena),   64'(1));
        rst = 1'b0;
        bus.op_valid = 1'b0;
        tick();

        // MTHI
        t0 = cyc;
        expect_wr(CS_HI, 32'h1234_5678, 32'h0, t0 + 1);
        issue(MD_MTHI, 32'h1234_5678, 32'h0);
        check("mthi_stall_wr", 64'(bus.stall), 64'(1));
        tick();
        check("mthi_stall_idle", 64'(bus.stall), 64'(0));
        bus.op_valid = 1'b0;
        tick();

        // MULT -3 * 7, 4-cycle multiplier
        mul_lat = 4;
        t0 = cyc;
        expect_wr(CS_BOTH, 32'hFFFF_FFFF, 32'hFFFF_FFEB, t0 + 6);
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_start",  64'(bus.mul_start),  64'(1));
        check("mult_signed", 64'(bus.mul_signed), 64'(1));
        check("mult_a",      64'(bus.mul_a),      64'(32'hFFFF_FFFD));
        check("mult_b",      64'(bus.mul_b),      64'(7));
        check("mult_no_div", 64'(bus.div_start),  64'(0));
        for (int k = 1; k <= 6; k++) begin
            check("mult_stall", 64'(bus.stall), 64'(1));
            if (k == 2) check("mult_start_pulse", 64'(bus.mul_start), 64'(0));
            tick();
        end
        check("mult_stall_done", 64'(bus.stall), 64'(0));
        bus.op_valid = 1'b0;

        // MULTU with a one-cycle multiplier
        mul_lat = 1;
        t0 = cyc;
        expect_wr(CS_BOTH, 32'h0000_0001, 32'hFFFF_FFFE, t0 + 3);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_signed", 64'(bus.mul_signed), 64'(0));
        for (int k = 0; k < 3; k++) tick();
        bus.op_valid = 1'b0;

        // DIVU by zero
        t0 = cyc;
        expect_wr(CS_BOTH, 32'd100, 32'hFFFF_FFFF, t0 + 1);
        issue(MD_DIVU, 32'd100, 32'd0);
        check("div0_no_start", 64'(bus.div_start), 64'(0));
        tick();
        check("div0_no_start2", 64'(bus.div_start), 64'(0));
        bus.op_valid = 1'b0;

        // DIV -7 / 2, 3-cycle divider
        div_lat = 3;
        t0 = cyc;
        expect_wr(CS_BOTH, 32'hFFFF_FFFF, 32'hFFFF_FFFD, t0 + 5);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_start",  64'(bus.div_start),  64'(1));
        check("div_signed", 64'(bus.div_signed), 64'(1));
        check("div_b",      64'(bus.div_b),      64'(2));
        check("div_no_mul", 64'(bus.mul_start),  64'(0));
        for (int k = 0; k < 5; k++) tick();
        check("div_stall_done", 64'(bus.stall), 64'(0));
        bus.op_valid = 1'b0;

        // DIVU 100 / 7 while the multiplier asserts a stray done
        div_lat = 4;
        t0 = cyc;
        expect_wr(CS_BOTH, 32'd2, 32'd14, t0 + 6);
        issue(MD_DIVU, 32'd100, 32'd7);
        mul_spur = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        mul_spur = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        tick();

        // Enable low blocks acceptance, then holds the write strobe off
        bus.ena      = 1'b0;
        bus.op_valid = 1'b1;
        bus.op       = MD_MTLO;
        bus.rs_data  = 32'hAAAA_5555;
        #1;
        check("frz_hilo_ena", 64'(bus.hilo_ena), 64'(0));
        tick();
        check("frz_stall", 64'(bus.stall), 64'(0));
        tick();
        bus.ena = 1'b1;
        t0 = cyc;
        expect_wr(CS_LO, 32'h0, 32'hAAAA_5555, t0 + 2);
        tick();
        bus.op  = MD_NOP;
        bus.ena = 1'b0;
        #1;
        check("frz_wena", 64'(bus.hilo_wena), 64'(0));
        tick();
        bus.ena = 1'b1;
        tick();
        check("frz_stall_after", 64'(bus.stall), 64'(0));
        bus.op_valid = 1'b0;

        // Divider never finishes: watchdog abort
        div_hang = 1'b1;
        t0 = cyc;
        issue(MD_DIV, 32'd5, 32'd3);
        bus.op_valid = 1'b0;
        seen = 0;
        for (int k = 1; k < 200; k++) begin
            if (bus.md_err === 1'b1) begin
                seen = k;
                break;
            end
            tick();
        end
        check("wd_err_cycle", 64'(seen), 64'(65));
        tick();
        check("wd_err_pulse", 64'(bus.md_err), 64'(0));
        div_hang = 1'b0;
        t0 = cyc;
        expect_wr(CS_LO, 32'h0, 32'h0BAD_F00D, t0 + 1);
        issue(MD_MTLO, 32'h0BAD_F00D, 32'h0);
        tick();
        bus.op_valid = 1'b0;

        // Reset two cycles into DIV_WAIT; the later done must be dropped
        div_lat = 5;
        issue(MD_DIV, 32'd50, 32'd5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mf_req = 1'b1;
        bus.mf_hi  = 1'b1;
        #1;
        for (int k = 3; k <= 9; k++) begin
            check("rstmid_stall", 64'(bus.stall),  64'(0));
            check("rstmid_err",   64'(bus.md_err), 64'(0));
            check("rstmid_cs",    64'(bus.hilo_cs), 64'(2'b10));
            tick();
        end
        bus.mf_req   = 1'b0;
        bus.op_valid = 1'b0;

        // Reset in the same cycle as done
        div_lat = 3;
        issue(MD_DIVU, 32'd9, 32'd4);
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstdone_stall", 64'(bus.stall), 64'(0));
        tick();
        check("rstdone_stall2", 64'(bus.stall), 64'(0));
        bus.op_valid = 1'b0;

        // MFLO held off while DIVU is busy
        div_lat = 6;
        t0 = cyc;
        expect_wr(CS_BOTH, 32'd1, 32'd333, t0 + 8);
        issue(MD_DIVU, 32'd1000, 32'd3);
        bus.op_valid = 1'b0;
        bus.mf_req   = 1'b1;
        bus.mf_hi    = 1'b0;
        #1;
        for (int k = 1; k <= 8; k++) begin
            check("mflo_stall", 64'(bus.stall), 64'(1));
            tick();
        end
        check("mflo_release", 64'(bus.stall),   64'(0));
        check("mflo_cs",      64'(bus.hilo_cs), 64'(2'b00));
        bus.mf_hi = 1'b1;
        #1;
        check("mfhi_cs", 64'(bus.hilo_cs), 64'(2'b10));
        bus.mf_req = 1'b0;

        tick();
        tick();
        check("sb_drain", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
